accel_host_mem: RTL and testbench
=================================

// Module: accel_host_mem
// PURPOSE
//  Host-side counterpart of the accelerator's memory and control interface.
//  Holds a DEPTH x 64-bit operand/result memory. Serves accelerator reads and accepts its result writes.
//  Sequences one job: load op_a/op_b, pulse comp_enb, wait for busyb/done, fetch the result, present it to the system.
// PARAMETERS
//  DEPTH     16   memory words (64-bit); valid addresses 0..DEPTH-1
//  ADDR_A    0    word written with op_a
//  ADDR_B    1    word written with op_b
//  ADDR_RES  2    word read back as result
//  TIMEOUT   64   max cycles in WAIT before abort
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  rst            in   1   synchronous active-high reset
//  start          in   1   job request, sampled in IDLE only
//  op_a           in   64  operand A, captured with start
//  op_b           in   64  operand B, captured with start
//  result         out  64  fetched word mem[ADDR_RES]; holds until next fetch
//  result_valid   out  1   1-cycle pulse, result updated
//  busy           out  1   high in every state except IDLE
//  timeout_err    out  1   sticky; set on timeout, cleared by accepted start or rst
//  comp_enb       out  1   accelerator restart; registered, high exactly 1 cycle per job
//  mem_addr       in   16  accelerator read address
//  mem_read_enb   in   1   active-low read enable
//  mem_data       out  64  read data
//  mem_write_enb  in   1   active-low write enable
//  res_addr       in   16  accelerator write address
//  res_data       in   64  accelerator write data
//  busyb          in   1   accelerator status, 0 while working
//  done           in   1   accelerator finished
// BEHAVIOUR
//  Reset: FSM=IDLE; memory cleared to 0; result=0; result_valid=0.
//   Also at reset: busy=0, timeout_err=0, comp_enb=0, wait counter=0, armed=0. Reset mid-job aborts with no result_valid.
//  Read port, combinational:
//   mem_data = mem[mem_addr] when mem_read_enb==0 and mem_addr<DEPTH, else 64'h0.
//   Data is valid in the same cycle the address is presented.
//  Write port: at a rising edge with mem_write_enb==0 and res_addr<DEPTH, mem[res_addr]<=res_data.
//   Writes with res_addr>=DEPTH are dropped.
//  Write conflict: in LOAD_A/LOAD_B the host write wins and the accelerator write is dropped.
//  FSM:
//   IDLE: start=1 -> latch op_a/op_b, clear timeout_err -> LOAD_A. start while not IDLE is ignored.
//   LOAD_A: mem[ADDR_A]<=op_a -> LOAD_B.
//   LOAD_B: mem[ADDR_B]<=op_b; comp_enb<=1 -> KICK.
//   KICK: comp_enb<=0; counter<=0; armed<=0 -> WAIT.
//   WAIT: counter++ each cycle. busyb==0 sets armed.
//     done==1 && armed -> FETCH. Done is not qualified until armed, so a stale done from the previous job is ignored.
//     If counter reaches TIMEOUT-1 without that exit -> timeout_err<=1, go to IDLE, no result_valid.
//     done and the timeout on the same cycle: done wins.
//   FETCH: result<=mem[ADDR_RES]; result_valid<=1 -> IDLE.
//  result_valid is deasserted the following cycle.
//  Timing with the team's accelerator:
//   start sampled at E0 -> comp_enb high in the cycle after E2.
//   The accelerator reads addr 0 and 1 and writes ADDR_RES at E9.
//   result_valid is high in the cycle after E11 (11-cycle latency). Benches check <=16.
//  All arithmetic is done in the accelerator. This block stores 64-bit words unmodified; no width conversion.
// TESTING
//  1 Basic job: op_a=5, op_b=7, start, accelerator model attached
//     -> comp_enb is a 1-cycle pulse; result_valid with result=12 within 16 cycles; busy=0 afterwards.
//  2 Wrap: op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2 -> result=64'h1; mem[0] and mem[1] hold the operands.
//  3 Stale done: run two jobs back to back (3+4, then 10+20)
//     -> second result=30, not 7; done held high from job 1 does not end WAIT early.
//  4 Timeout: busyb held 1 and done held 0
//     -> after 64 WAIT cycles timeout_err=1, no result_valid, FSM in IDLE; next start clears timeout_err.
//  5 Boundary: read mem_addr=16 -> mem_data=0; write res_addr=20 -> no memory change.
//     mem_read_enb=1 -> mem_data=0 regardless of address.
//  6 Reset mid-job: assert rst in WAIT -> next cycle comp_enb=0, busy=0, result=0.
//     A following start completes normally.

Source files
------------

// File: rtl/accel_host_mem.sv
// Host side of the accelerator link: a DEPTH x 64-bit operand/result memory
// plus the sequencer that loads operands, kicks the accelerator and fetches its result.
module accel_host_mem #(
  parameter int DEPTH    = 16,
  parameter int ADDR_A   = 0,
  parameter int ADDR_B   = 1,
  parameter int ADDR_RES = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        comp_enb,
  input  logic [15:0] mem_addr,
  input  logic        mem_read_enb,
  output logic [63:0] mem_data,
  input  logic        mem_write_enb,
  input  logic [15:0] res_addr,
  input  logic [63:0] res_data,
  input  logic        busyb,
  input  logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, KICK, WAIT, FETCH} state_t;

  state_t        state, state_next;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   op_a_q, op_b_q;
  logic [CW-1:0] wait_cnt;
  logic          armed;
  logic          wait_done, wait_expired;

  // done only counts once the accelerator has shown it started this job
  assign wait_done    = done && armed;
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
  assign busy         = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = KICK;
      KICK:    state_next = WAIT;
      WAIT: begin
        if (wait_done)         state_next = FETCH;
        else if (wait_expired) state_next = IDLE;
      end
      FETCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      comp_enb     <= 1'b0;
      wait_cnt     <= '0;
      armed        <= 1'b0;
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      comp_enb     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a_q      <= op_a;
            op_b_q      <= op_b;
            timeout_err <= 1'b0;
          end
        end
        LOAD_B: comp_enb <= 1'b1;
        KICK: begin
          wait_cnt <= '0;
          armed    <= 1'b0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!busyb) armed <= 1'b1;
          if (!wait_done && wait_expired) timeout_err <= 1'b1;
        end
        FETCH: begin
          result       <= mem[AW'(ADDR_RES)];
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Host operand loads take priority over any accelerator write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == LOAD_A) begin
      mem[AW'(ADDR_A)] <= op_a_q;
    end else if (state == LOAD_B) begin
      mem[AW'(ADDR_B)] <= op_b_q;
    end else if (!mem_write_enb && ({1'b0, res_addr} < DEPTH_L)) begin
      mem[res_addr[AW-1:0]] <= res_data;
    end
  end

  always_comb begin
    mem_data = '0;
    if (!mem_read_enb && ({1'b0, mem_addr} < DEPTH_L))
      mem_data = mem[mem_addr[AW-1:0]];
  end

endmodule

// File: tb/tb_accel_host_mem.sv
// Scoreboard bench for accel_host_mem with a small accelerator model that adds the two operands.
module tb_accel_host_mem;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] op_a, op_b;
  logic [63:0] result;
  logic        result_valid, busy, timeout_err, comp_enb;
  logic [15:0] mem_addr;
  logic        mem_read_enb;
  logic [63:0] mem_data;
  logic        mem_write_enb;
  logic [15:0] res_addr;
  logic [63:0] res_data;
  logic        busyb, done;

  typedef struct {
    logic [63:0] res;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   prev_valid = 0;

  accel_host_mem dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .result(result), .result_valid(result_valid), .busy(busy),
    .timeout_err(timeout_err), .comp_enb(comp_enb),
    .mem_addr(mem_addr), .mem_read_enb(mem_read_enb), .mem_data(mem_data),
    .mem_write_enb(mem_write_enb), .res_addr(res_addr), .res_data(res_data),
    .busyb(busyb), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result_valid must match the oldest outstanding job
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else begin
      if (prev_valid) checkOutput("result_valid pulse width", 64'(result_valid), 64'd0);
      if (result_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected result_valid", 64'(result_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("result", result, mon_e.res);
          checks++;
          if (cyc - mon_e.start_cyc > 16) begin
            fails++;
            $display("[TB] FAIL latency: got %0d cycles, required <= 16", cyc - mon_e.start_cyc);
          end
        end
      end
      prev_valid = result_valid;
    end
  end

  // Issues one job and plays the accelerator: read A and B, write A+B to word 2, raise done
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res);
    logic [63:0] rd_a, rd_b;
    bit          seen;
    exp_t        e;
    start = 1; op_a = a; op_b = b;
    tick();
    start = 0;
    e.res = exp_res;
    e.start_cyc = cyc;
    sb.push_back(e);
    checkOutput("timeout_err cleared by start", 64'(timeout_err), 64'd0);
    checkOutput("busy after start", 64'(busy), 64'd1);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = comp_enb;
    end
    checkOutput("comp_enb asserted", 64'(seen), 64'd1);
    if (!seen) begin
      sb.delete();
      return;
    end
    tick();
    checkOutput("comp_enb single cycle", 64'(comp_enb), 64'd0);
    tick();
    busyb = 0; done = 0;
    tick();
    mem_addr = 16'd0; mem_read_enb = 0;
    @(negedge clk);
    rd_a = mem_data;
    tick();
    mem_addr = 16'd1;
    @(negedge clk);
    rd_b = mem_data;
    checkOutput("mem[0] operand", rd_a, a);
    checkOutput("mem[1] operand", rd_b, b);
    tick();
    mem_read_enb = 1;
    tick();
    res_addr = 16'd2; res_data = rd_a + rd_b; mem_write_enb = 0;
    tick();
    mem_write_enb = 1; done = 1; busyb = 1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checkOutput("pending results", 64'(sb.size()), 64'd0);
    sb.delete();
    checkOutput("busy after job", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; op_a = 0; op_b = 0;
    mem_addr = 0; mem_read_enb = 1; mem_write_enb = 1;
    res_addr = 0; res_data = 0; busyb = 1; done = 0;
    repeat (3) tick();
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset result_valid", 64'(result_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset timeout_err", 64'(timeout_err), 64'd0);
    checkOutput("reset comp_enb", 64'(comp_enb), 64'd0);
    rst = 0;
    mem_read_enb = 0; mem_addr = 16'd2;
    #1 checkOutput("reset mem[2]", mem_data, 64'd0);
    mem_read_enb = 1;
    tick();

    $display("[TB] basic job 5+7");
    applyStimulus(64'd5, 64'd7, 64'd12);

    $display("[TB] wrap job");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1);
    mem_read_enb = 0; mem_addr = 16'd0;
    #1 checkOutput("mem[0] holds op_a", mem_data, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_addr = 16'd1;
    #1 checkOutput("mem[1] holds op_b", mem_data, 64'd2);
    mem_read_enb = 1;

    $display("[TB] back-to-back jobs with stale done");
    applyStimulus(64'd3, 64'd4, 64'd7);
    applyStimulus(64'd10, 64'd20, 64'd30);

    $display("[TB] timeout");
    done = 0; busyb = 1;
    start = 1; op_a = 64'd9; op_b = 64'd9;
    tick();
    start = 0;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      start = (n == 20);
    end
    start = 0;
    checkOutput("cycles until timeout abort", 64'(n), 64'd67);
    checkOutput("timeout_err set", 64'(timeout_err), 64'd1);
    checkOutput("result kept after timeout", result, 64'd30);
    tick();
    checkOutput("timeout_err sticky", 64'(timeout_err), 64'd1);
    applyStimulus(64'd40, 64'd2, 64'd42);

    $display("[TB] address boundaries");
    mem_read_enb = 0; mem_addr = 16'd16;
    #1 checkOutput("read addr 16", mem_data, 64'd0);
    mem_addr = 16'hFFFF;
    #1 checkOutput("read addr FFFF", mem_data, 64'd0);
    mem_addr = 16'd2;
    #1 checkOutput("read addr 2", mem_data, 64'd42);
    mem_read_enb = 1;
    #1 checkOutput("read disabled", mem_data, 64'd0);
    res_addr = 16'd20; res_data = 64'hDEAD_BEEF; mem_write_enb = 0;
    tick();
    mem_write_enb = 1;
    mem_read_enb = 0; mem_addr = 16'd4;
    #1 checkOutput("out-of-range write dropped", mem_data, 64'd0);
    res_addr = 16'd5; res_data = 64'h1234_5678; mem_write_enb = 0;
    tick();
    mem_write_enb = 1; mem_addr = 16'd5;
    #1 checkOutput("in-range write", mem_data, 64'h1234_5678);
    mem_read_enb = 1;

    $display("[TB] reset mid-job");
    done = 0; busyb = 1;
    start = 1; op_a = 64'd77; op_b = 64'd88;
    tick();
    start = 0;
    repeat (6) tick();
    checkOutput("busy in WAIT", 64'(busy), 64'd1);
    rst = 1;
    tick();
    checkOutput("rst comp_enb", 64'(comp_enb), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst result", result, 64'd0);
    checkOutput("rst result_valid", 64'(result_valid), 64'd0);
    mem_read_enb = 0; mem_addr = 16'd5;
    #1 checkOutput("rst clears memory", mem_data, 64'd0);
    mem_read_enb = 1;
    rst = 0;
    tick();
    applyStimulus(64'd100, 64'd23, 64'd123);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
